tug_war_referee: RTL

Round controller and arbiter for the tug-of-war light field. It synchronizes and edge-detects the two player keys and can replace the left player with an LFSR-driven computer player. It gates the resulting single-cycle press pulses onto the shared L/R lines of the light array, detects when a point is scored off either end, and keeps score. It holds the field in reset between points and after game over.

---
 rtl/tug_war_referee.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tug_war_referee.sv
// Round controller for the tug-of-war light field: key sync/edge detect, optional
// LFSR computer player, pulse arbitration onto the cell array, scoring and restart.
module tug_war_referee #(
  parameter int N_LIGHTS       = 9,
  parameter int WIN_SCORE      = 7,
  parameter int RESTART_CYCLES = 4,
  parameter int CPU_DIV        = 1024,
  parameter int LFSR_W         = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_l_raw,
  input  logic              key_r_raw,
  input  logic              cpu_enable,
  input  logic [LFSR_W-1:0] cpu_threshold,
  input  logic [N_LIGHTS-1:0] lights_in,
  output logic              l_pulse,
  output logic              r_pulse,
  output logic              field_reset,
  output logic [2:0]        score_l,
  output logic [2:0]        score_r,
  output logic [1:0]        winner
);

  localparam logic [1:0] ST_FIELD_RST = 2'd0;
  localparam logic [1:0] ST_PLAY      = 2'd1;
  localparam logic [1:0] ST_POINT     = 2'd2;
  localparam logic [1:0] ST_GAMEOVER  = 2'd3;

  localparam int DIV_W = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;
  localparam int CNT_W = $clog2(RESTART_CYCLES + 2);

  // Second feedback tap (1-based) of a maximal two-tap Fibonacci LFSR.
  function automatic int lfsr_tap2(input int w);
    case (w)
      3:       return 2;
      4:       return 3;
      5:       return 3;
      6:       return 5;
      7:       return 6;
      9:       return 5;
      10:      return 7;
      11:      return 9;
      15:      return 14;
      17:      return 14;
      default: return w - 1;
    endcase
  endfunction

  localparam int TAP2 = lfsr_tap2(LFSR_W);

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  logic              r_l_s1, r_l_s2, r_l_d;
  logic              r_r_s1, r_r_s2, r_r_d;
  logic [LFSR_W-1:0] r_lfsr;
  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_point_l;
  logic              r_l_pulse, r_r_pulse, r_field_reset;
  logic [2:0]        r_score_l, r_score_r;
  logic [1:0]        r_winner;

  logic              w_key_cand_l, w_cand_l, w_cand_r, w_cpu_cand;
  logic              w_div_tc;
  logic              w_fwd_l, w_fwd_r;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [2:0]        w_new_score;
  logic              w_unused;

  assign w_unused = ^lights_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_l_s1 <= 1'b0;
      r_l_s2 <= 1'b0;
      r_l_d  <= 1'b0;
      r_r_s1 <= 1'b0;
      r_r_s2 <= 1'b0;
      r_r_d  <= 1'b0;
      r_lfsr <= LFSR_W'(1);
      r_div  <= '0;
    end else begin
      r_l_s1 <= key_l_raw;
      r_l_s2 <= r_l_s1;
      r_l_d  <= r_l_s2;
      r_r_s1 <= key_r_raw;
      r_r_s2 <= r_r_s1;
      r_r_d  <= r_r_s2;
      r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_W-1] ^ r_lfsr[TAP2-1]};
      r_div  <= w_div_tc ? '0 : r_div + DIV_W'(1);
    end
  end

  assign w_div_tc     = (r_div == DIV_W'(CPU_DIV - 1));
  assign w_cpu_cand   = w_div_tc && (r_lfsr < cpu_threshold);
  assign w_key_cand_l = r_l_s2 & ~r_l_d;
  assign w_cand_l     = cpu_enable ? w_cpu_cand : w_key_cand_l;
  assign w_cand_r     = r_r_s2 & ~r_r_d;

  // Simultaneous candidates cancel each other; only PLAY forwards anything.
  assign w_fwd_l = (r_state == ST_PLAY) && w_cand_l && !w_cand_r;
  assign w_fwd_r = (r_state == ST_PLAY) && w_cand_r && !w_cand_l;

  assign w_new_score = r_point_l ? sat_inc(r_score_l) : sat_inc(r_score_r);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_FIELD_RST: begin
        if (r_cnt == '0) w_state_nxt = ST_PLAY;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_PLAY: begin
        if ((w_fwd_l && lights_in[N_LIGHTS-1]) || (w_fwd_r && lights_in[0]))
          w_state_nxt = ST_POINT;
      end
      ST_POINT: begin
        if (w_new_score == 3'(WIN_SCORE)) begin
          w_state_nxt = ST_GAMEOVER;
        end else begin
          w_state_nxt = ST_FIELD_RST;
          w_cnt_nxt   = CNT_W'(RESTART_CYCLES - 1);
        end
      end
      ST_GAMEOVER: w_state_nxt = ST_GAMEOVER;
      default:     w_state_nxt = ST_FIELD_RST;
    endcase
  end

  // Reset loads one extra count so the first PLAY follows RESTART_CYCLES+1 edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_FIELD_RST;
      r_cnt         <= CNT_W'(RESTART_CYCLES);
      r_point_l     <= 1'b0;
      r_l_pulse     <= 1'b0;
      r_r_pulse     <= 1'b0;
      r_field_reset <= 1'b1;
      r_score_l     <= '0;
      r_score_r     <= '0;
      r_winner      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_l_pulse     <= w_fwd_l;
      r_r_pulse     <= w_fwd_r;
      r_field_reset <= (w_state_nxt == ST_FIELD_RST) || (w_state_nxt == ST_GAMEOVER);
      if (r_state == ST_PLAY && w_state_nxt == ST_POINT)
        r_point_l <= w_fwd_l;
      if (r_state == ST_POINT) begin
        if (r_point_l) r_score_l <= w_new_score;
        else           r_score_r <= w_new_score;
        if (w_new_score == 3'(WIN_SCORE))
          r_winner <= r_point_l ? 2'b10 : 2'b01;
      end
    end
  end

  assign l_pulse     = r_l_pulse;
  assign r_pulse     = r_r_pulse;
  assign field_reset = r_field_reset;
  assign score_l     = r_score_l;
  assign score_r     = r_score_r;
  assign winner      = r_winner;

endmodule
